// File: rtl/core_pkg.sv
// Shared widths, reservation-station entry layout and operand tag helper
// for the integer execute path.
package core_pkg;

    localparam int ROBID_W = 7;
    localparam int OP_W    = 5;
    localparam int RD_W    = 6;
    localparam int XLEN    = 32;

    typedef struct packed {
        logic               valid;
        logic [OP_W-1:0]    op;
        logic [ROBID_W-1:0] robid;
        logic [RD_W-1:0]    rd;
        logic               r1;
        logic [XLEN-1:0]    v1;
        logic               r2;
        logic [XLEN-1:0]    v2;
        logic [XLEN-1:0]    imm;
    } exers_entry_t;

    // An operand that is not yet ready carries its producer tag in the low bits.
    function automatic logic [ROBID_W-1:0] tag_of(input logic [XLEN-1:0] opnd);
        return opnd[ROBID_W-1:0];
    endfunction

endpackage

// File: rtl/exers_age.sv
// Age matrix for the reservation station: age_r[i][j]=1 means entry i is
// older than entry j. Produces a one-hot oldest-ready vector.
module exers_age #(
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [DEPTH-1:0] wr,
    input  logic [DEPTH-1:0] valid,
    input  logic [DEPTH-1:0] free,
    input  logic [DEPTH-1:0] ready,
    output logic [DEPTH-1:0] oldest
);

    logic [DEPTH-1:0][DEPTH-1:0] age_r;
    logic [DEPTH-1:0]            blk_s;

    // Matrix update: a new entry is younger than every surviving valid entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            age_r <= '0;
        end else if (flush) begin
            age_r <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                for (int j = 0; j < DEPTH; j++) begin
                    if (wr[i]) begin
                        age_r[i][j] <= 1'b0;
                    end else if (wr[j]) begin
                        age_r[i][j] <= valid[i] & ~free[i];
                    end else if (free[i] | free[j]) begin
                        age_r[i][j] <= 1'b0;
                    end else begin
                        age_r[i][j] <= age_r[i][j];
                    end
                end
            end
        end
    end

    // An entry is blocked when some older entry is also ready.
    always_comb begin
        blk_s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
                if ((i != j) && ready[j] && age_r[j][i]) begin
                    blk_s[i] = 1'b1;
                end else begin
                    blk_s[i] = blk_s[i];
                end
            end
        end
        oldest = ready & ~blk_s;
    end

endmodule

// File: rtl/exers.sv
// Integer execute reservation station: captures renamed ops, snoops the CDB
// for source tags and issues the oldest ready op through a registered port.
module exers
    import core_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int IDXW  = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rename_exers_write,
    input  logic [OP_W-1:0]     rename_op,
    input  logic [ROBID_W-1:0]  rename_robid,
    input  logic [RD_W-1:0]     rename_rd,
    input  logic                rename_op1ready,
    input  logic [XLEN-1:0]     rename_op1,
    input  logic                rename_op2ready,
    input  logic [XLEN-1:0]     rename_op2,
    input  logic [XLEN-1:0]     rename_imm,
    output logic                exers_stall,
    input  logic                wb_valid,
    input  logic [ROBID_W-1:0]  wb_robid,
    input  logic [XLEN-1:0]     wb_result,
    input  logic                alu_stall,
    output logic                exers_issue_valid,
    output logic [OP_W-1:0]     exers_issue_op,
    output logic [ROBID_W-1:0]  exers_issue_robid,
    output logic [RD_W-1:0]     exers_issue_rd,
    output logic [XLEN-1:0]     exers_issue_op1,
    output logic [XLEN-1:0]     exers_issue_op2,
    output logic [XLEN-1:0]     exers_issue_imm,
    input  logic                rob_flush
);

    exers_entry_t     ent_r [DEPTH];
    exers_entry_t     new_ent_s;
    exers_entry_t     sel_ent_s;
    logic [DEPTH-1:0] valid_s;
    logic [DEPTH-1:0] free_s;
    logic [DEPTH-1:0] ready_s;
    logic [DEPTH-1:0] wr_oh_s;
    logic [DEPTH-1:0] oldest_s;
    logic [DEPTH-1:0] sel_oh_s;
    logic [DEPTH-1:0] wake1_s;
    logic [DEPTH-1:0] wake2_s;
    logic [IDXW:0]    free_cnt_s;
    logic             issue_ld_s;
    logic             sel_any_s;

    // Per-entry status and CDB tag compare, all from registered state.
    for (genvar g = 0; g < DEPTH; g++) begin : g_ent
        assign valid_s[g] = ent_r[g].valid;
        assign ready_s[g] = ent_r[g].valid & ent_r[g].r1 & ent_r[g].r2;
        assign wake1_s[g] = wb_valid & ent_r[g].valid & ~ent_r[g].r1
                          & (tag_of(ent_r[g].v1) == wb_robid);
        assign wake2_s[g] = wb_valid & ent_r[g].valid & ~ent_r[g].r2
                          & (tag_of(ent_r[g].v2) == wb_robid);
    end

    assign free_s = ~valid_s;

    // Lowest set bit of the free vector; empty when full, which drops the write.
    assign wr_oh_s = rename_exers_write
                   ? (free_s & (~free_s + {{(DEPTH-1){1'b0}}, 1'b1}))
                   : {DEPTH{1'b0}};

    // Free slot count from registered valid bits only.
    always_comb begin
        free_cnt_s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            free_cnt_s = free_cnt_s + {{IDXW{1'b0}}, free_s[i]};
        end
    end

    // Same as (free - write) == 0 for legal traffic, and stays asserted when full.
    assign exers_stall = (free_cnt_s <= {{IDXW{1'b0}}, rename_exers_write});

    // Incoming entry, capturing a same-cycle CDB result for a waiting operand.
    always_comb begin
        new_ent_s.valid = 1'b1;
        new_ent_s.op    = rename_op;
        new_ent_s.robid = rename_robid;
        new_ent_s.rd    = rename_rd;
        new_ent_s.imm   = rename_imm;
        if (rename_op1ready) begin
            new_ent_s.r1 = 1'b1;
            new_ent_s.v1 = rename_op1;
        end else if (wb_valid && (tag_of(rename_op1) == wb_robid)) begin
            new_ent_s.r1 = 1'b1;
            new_ent_s.v1 = wb_result;
        end else begin
            new_ent_s.r1 = 1'b0;
            new_ent_s.v1 = rename_op1;
        end
        if (rename_op2ready) begin
            new_ent_s.r2 = 1'b1;
            new_ent_s.v2 = rename_op2;
        end else if (wb_valid && (tag_of(rename_op2) == wb_robid)) begin
            new_ent_s.r2 = 1'b1;
            new_ent_s.v2 = wb_result;
        end else begin
            new_ent_s.r2 = 1'b0;
            new_ent_s.v2 = rename_op2;
        end
    end

    exers_age #(
        .DEPTH (DEPTH)
    ) u_age (
        .clk    (clk),
        .rst    (rst),
        .flush  (rob_flush),
        .wr     (wr_oh_s),
        .valid  (valid_s),
        .free   (sel_oh_s),
        .ready  (ready_s),
        .oldest (oldest_s)
    );

    assign issue_ld_s = ~exers_issue_valid | ~alu_stall;
    assign sel_oh_s   = issue_ld_s ? oldest_s : {DEPTH{1'b0}};
    assign sel_any_s  = |sel_oh_s;

    // One-hot mux of the selected entry; all zero when nothing is selected.
    always_comb begin
        sel_ent_s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sel_oh_s[i]) begin
                sel_ent_s = ent_r[i];
            end else begin
                sel_ent_s = sel_ent_s;
            end
        end
    end

    // Entry storage: flush beats write and wakeup; selection frees the slot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_r[i] <= '0;
            end
        end else if (rob_flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_r[i].valid <= 1'b0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_oh_s[i]) begin
                    ent_r[i] <= new_ent_s;
                end else begin
                    if (sel_oh_s[i]) begin
                        ent_r[i].valid <= 1'b0;
                    end
                    if (wake1_s[i]) begin
                        ent_r[i].r1 <= 1'b1;
                        ent_r[i].v1 <= wb_result;
                    end
                    if (wake2_s[i]) begin
                        ent_r[i].r2 <= 1'b1;
                        ent_r[i].v2 <= wb_result;
                    end
                end
            end
        end
    end

    // Issue register: reloads whenever empty or the ALU accepts, else holds.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exers_issue_valid <= 1'b0;
            exers_issue_op    <= '0;
            exers_issue_robid <= '0;
            exers_issue_rd    <= '0;
            exers_issue_op1   <= '0;
            exers_issue_op2   <= '0;
            exers_issue_imm   <= '0;
        end else if (rob_flush) begin
            exers_issue_valid <= 1'b0;
            exers_issue_op    <= '0;
            exers_issue_robid <= '0;
            exers_issue_rd    <= '0;
            exers_issue_op1   <= '0;
            exers_issue_op2   <= '0;
            exers_issue_imm   <= '0;
        end else if (issue_ld_s) begin
            exers_issue_valid <= sel_any_s;
            exers_issue_op    <= sel_ent_s.op;
            exers_issue_robid <= sel_ent_s.robid;
            exers_issue_rd    <= sel_ent_s.rd;
            exers_issue_op1   <= sel_ent_s.v1;
            exers_issue_op2   <= sel_ent_s.v2;
            exers_issue_imm   <= sel_ent_s.imm;
        end
    end

endmodule

// File: tb/tb_exers.sv
// Scoreboard bench for the exers reservation station.
module tb_exers;

    typedef struct packed {
        logic [4:0]  op;
        logic [6:0]  robid;
        logic [5:0]  rd;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] imm;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        rename_exers_write;
    logic [4:0]  rename_op;
    logic [6:0]  rename_robid;
    logic [5:0]  rename_rd;
    logic        rename_op1ready;
    logic [31:0] rename_op1;
    logic        rename_op2ready;
    logic [31:0] rename_op2;
    logic [31:0] rename_imm;
    logic        exers_stall;
    logic        wb_valid;
    logic [6:0]  wb_robid;
    logic [31:0] wb_result;
    logic        alu_stall;
    logic        exers_issue_valid;
    logic [4:0]  exers_issue_op;
    logic [6:0]  exers_issue_robid;
    logic [5:0]  exers_issue_rd;
    logic [31:0] exers_issue_op1;
    logic [31:0] exers_issue_op2;
    logic [31:0] exers_issue_imm;
    logic        rob_flush;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb_q[$];
    exp_t sb_e;

    exers dut (
        .clk                (clk),
        .rst                (rst),
        .rename_exers_write (rename_exers_write),
        .rename_op          (rename_op),
        .rename_robid       (rename_robid),
        .rename_rd          (rename_rd),
        .rename_op1ready    (rename_op1ready),
        .rename_op1         (rename_op1),
        .rename_op2ready    (rename_op2ready),
        .rename_op2         (rename_op2),
        .rename_imm         (rename_imm),
        .exers_stall        (exers_stall),
        .wb_valid           (wb_valid),
        .wb_robid           (wb_robid),
        .wb_result          (wb_result),
        .alu_stall          (alu_stall),
        .exers_issue_valid  (exers_issue_valid),
        .exers_issue_op     (exers_issue_op),
        .exers_issue_robid  (exers_issue_robid),
        .exers_issue_rd     (exers_issue_rd),
        .exers_issue_op1    (exers_issue_op1),
        .exers_issue_op2    (exers_issue_op2),
        .exers_issue_imm    (exers_issue_imm),
        .rob_flush          (rob_flush)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one write; the slot must be free before the write is raised.
    task automatic set_wr(input logic [4:0] op, input logic [6:0] robid, input logic [5:0] rd,
                          input logic r1, input logic [31:0] v1,
                          input logic r2, input logic [31:0] v2,
                          input logic [31:0] imm, input bit push,
                          input logic [31:0] e1, input logic [31:0] e2);
        exp_t x;
        rename_exers_write = 1'b0;
        #1;
        check("wr_not_full", 32'(exers_stall), 32'd0);
        rename_op          = op;
        rename_robid       = robid;
        rename_rd          = rd;
        rename_op1ready    = r1;
        rename_op1         = v1;
        rename_op2ready    = r2;
        rename_op2         = v2;
        rename_imm         = imm;
        rename_exers_write = 1'b1;
        if (push) begin
            x.op = op; x.robid = robid; x.rd = rd;
            x.op1 = e1; x.op2 = e2; x.imm = imm;
            sb_q.push_back(x);
        end
    endtask

    task automatic clear_wr();
        rename_exers_write = 1'b0;
    endtask

    task automatic wb(input logic [6:0] tag, input logic [31:0] val);
        wb_valid  = 1'b1;
        wb_robid  = tag;
        wb_result = val;
    endtask

    task automatic wb_off();
        wb_valid = 1'b0;
    endtask

    // Consumption monitor: an op leaves the issue port when valid and not stalled.
    always @(negedge clk) begin
        if (rst && exers_issue_valid && !alu_stall) begin
            check("sb_pending", 32'(sb_q.size() > 0), 32'd1);
            if (sb_q.size() > 0) begin
                sb_e = sb_q.pop_front();
                check("sb_robid", 32'(exers_issue_robid), 32'(sb_e.robid));
                check("sb_op",    32'(exers_issue_op),    32'(sb_e.op));
                check("sb_rd",    32'(exers_issue_rd),    32'(sb_e.rd));
                check("sb_op1",   exers_issue_op1,        sb_e.op1);
                check("sb_op2",   exers_issue_op2,        sb_e.op2);
                check("sb_imm",   exers_issue_imm,        sb_e.imm);
            end
        end
    end

    initial begin
        rst = 1'b0;
        rename_exers_write = 1'b0; rename_op = 5'd0; rename_robid = 7'd0; rename_rd = 6'd0;
        rename_op1ready = 1'b0; rename_op1 = 32'd0; rename_op2ready = 1'b0; rename_op2 = 32'd0;
        rename_imm = 32'd0; wb_valid = 1'b0; wb_robid = 7'd0; wb_result = 32'd0;
        alu_stall = 1'b0; rob_flush = 1'b0;
        tick(); tick();
        check("rst_valid", 32'(exers_issue_valid), 32'd0);
        check("rst_robid", 32'(exers_issue_robid), 32'd0);
        check("rst_op1",   exers_issue_op1,        32'd0);
        check("rst_stall", 32'(exers_stall),       32'd0);
        rst = 1'b1;
        tick();

        // Single ready op: issue two cycles after the write edge.
        set_wr(5'd3, 7'd5, 6'd1, 1'b1, 32'd10, 1'b1, 32'd20, 32'hABC, 1'b1, 32'd10, 32'd20);
        tick(); clear_wr();
        check("single_n1_valid", 32'(exers_issue_valid), 32'd0);
        tick();
        check("single_n2_valid", 32'(exers_issue_valid), 32'd1);
        check("single_n2_robid", 32'(exers_issue_robid), 32'd5);
        tick();
        check("single_drained", 32'(exers_issue_valid), 32'd0);

        // Wakeup of op1 two cycles after the write.
        set_wr(5'd4, 7'd9, 6'd2, 1'b0, 32'h12, 1'b1, 32'd3, 32'd0, 1'b1, 32'hDEAD, 32'd3);
        tick(); clear_wr();
        tick();
        wb(7'h12, 32'hDEAD);
        tick(); wb_off();
        check("wake_b1_valid", 32'(exers_issue_valid), 32'd0);
        tick();
        check("wake_b2_valid", 32'(exers_issue_valid), 32'd1);
        check("wake_b2_robid", 32'(exers_issue_robid), 32'd9);
        tick();

        // Same-cycle write and matching broadcast.
        set_wr(5'd5, 7'h0A, 6'd3, 1'b1, 32'd1, 1'b0, 32'h21, 32'd0, 1'b1, 32'd1, 32'd7);
        wb(7'h21, 32'd7);
        tick(); clear_wr(); wb_off();
        check("cap_n1_valid", 32'(exers_issue_valid), 32'd0);
        tick();
        check("cap_n2_valid", 32'(exers_issue_valid), 32'd1);
        check("cap_n2_op2",   exers_issue_op2,        32'd7);
        tick();

        // Age order independent of slot index.
        set_wr(5'd1, 7'h30, 6'd4, 1'b1, 32'd1, 1'b0, 32'h50, 32'd0, 1'b1, 32'd1, 32'h55);
        tick();
        set_wr(5'd1, 7'd1, 6'd5, 1'b1, 32'd2, 1'b0, 32'h40, 32'd0, 1'b1, 32'd2, 32'h44);
        tick(); clear_wr();
        wb(7'h50, 32'h55);
        tick(); wb_off();
        tick();
        set_wr(5'd2, 7'd2, 6'd6, 1'b1, 32'd3, 1'b0, 32'h40, 32'd0, 1'b1, 32'd3, 32'h44);
        tick();
        set_wr(5'd2, 7'd3, 6'd7, 1'b0, 32'h40, 1'b0, 32'h40, 32'd0, 1'b1, 32'h44, 32'h44);
        tick(); clear_wr();
        wb(7'h40, 32'h44);
        tick(); wb_off();
        check("age_b1_valid", 32'(exers_issue_valid), 32'd0);
        for (int k = 1; k <= 3; k++) begin
            tick();
            check("age_seq", 32'(exers_issue_robid), 32'(k));
        end
        tick();
        check("age_done", 32'(exers_issue_valid), 32'd0);

        // Fill all slots with waiting ops.
        for (int i = 0; i < 8; i++) begin
            set_wr(5'd6, 7'(8'h10 + i), 6'd8, 1'b0, (i == 3) ? 32'h61 : 32'h60,
                   1'b1, 32'h100 + 32'(i), 32'd0, 1'b0, 32'd0, 32'd0);
            if (i == 7) begin
                #1;
                check("stall_7_plus_wr", 32'(exers_stall), 32'd1);
            end
            tick();
        end
        clear_wr();
        #1;
        check("stall_full", 32'(exers_stall), 32'd1);
        wb(7'h61, 32'h6161);
        tick(); wb_off();
        check("stall_wake_n1", 32'(exers_stall), 32'd1);
        check("full_wake_n1_v", 32'(exers_issue_valid), 32'd0);
        alu_stall = 1'b1;
        wb(7'h60, 32'h6060);
        tick(); wb_off();
        check("stall_freed", 32'(exers_stall), 32'd0);
        check("full_issue_v", 32'(exers_issue_valid), 32'd1);
        check("full_issue_id", 32'(exers_issue_robid), 32'h13);
        check("full_issue_op1", exers_issue_op1, 32'h6161);
        check("full_issue_op2", exers_issue_op2, 32'h103);

        // Held under alu_stall although other entries are now ready.
        for (int k = 0; k < 3; k++) begin
            tick();
            check("hold_valid", 32'(exers_issue_valid), 32'd1);
            check("hold_robid", 32'(exers_issue_robid), 32'h13);
            check("hold_op1",   exers_issue_op1,        32'h6161);
        end

        // Flush together with a write: everything discarded.
        set_wr(5'd7, 7'h7E, 6'd9, 1'b1, 32'd1, 1'b1, 32'd2, 32'd0, 1'b0, 32'd0, 32'd0);
        rob_flush = 1'b1;
        sb_q.delete();
        tick(); rob_flush = 1'b0; clear_wr();
        check("flush_valid", 32'(exers_issue_valid), 32'd0);
        check("flush_stall", 32'(exers_stall),       32'd0);
        alu_stall = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("flush_empty", 32'(exers_issue_valid), 32'd0);
        end

        // Normal operation after flush.
        set_wr(5'd7, 7'h22, 6'd9, 1'b1, 32'h1234, 1'b1, 32'h5678, 32'hFFFF0000, 1'b1,
               32'h1234, 32'h5678);
        tick(); clear_wr();
        tick();
        check("post_flush_id", 32'(exers_issue_robid), 32'h22);
        tick();

        // Asynchronous reset mid-operation leaves nothing behind.
        set_wr(5'd8, 7'h33, 6'd10, 1'b0, 32'h70, 1'b1, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0);
        tick(); clear_wr();
        #1; rst = 1'b0; #1;
        check("arst_valid", 32'(exers_issue_valid), 32'd0);
        check("arst_stall", 32'(exers_stall),       32'd0);
        rst = 1'b1;
        wb(7'h70, 32'h7070);
        tick(); wb_off();
        tick(); tick();
        check("arst_no_issue", 32'(exers_issue_valid), 32'd0);

        check("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
